garbage_inserter: RTL

//  Inverse of the row-clear path. Pushes N garbage rows in at the bottom of the

---
 rtl/garbage_inserter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/garbage_inserter.sv
// garbage_inserter
//   Pushes up to MAX_LINES garbage rows in at the bottom of the playfield,
//   one row per clock, shifting the stack up toward row 0. Used in versus
//   mode to apply lines sent by the opponent; sits between the lock/clear
//   sequence and the field register. Rows shifted past row 0 are discarded,
//   and topped_out is raised if any of them held an occupied cell.
//
//   Field layout: f[row][col][2:0]. Row 0 is the top row and row
//   FIELD_VERTICAL-1 is the bottom row. An empty cell is 3'b111.
//
// Ports
//   clk          in   1        system clock, rising edge
//   reset_n      in   1        asynchronous reset, active low
//   start        in   1        level request; held high until done is seen
//   f            in   field    field snapshot, sampled on load
//   lines        in   3        rows to insert, sampled on load
//   hole_col     in   4        empty column of the garbage rows, sampled on load
//   f_out        out  field    working/result field
//   lines_added  out  3        rows inserted so far in this request
//   busy         out  1        high while shifting
//   done         out  1        high once the request has completed
//   topped_out   out  1        sticky: an occupied row left the top this request

module garbage_inserter #(
  parameter logic [2:0] GARBAGE_CELL     = 3'b000,
  parameter int         MAX_LINES        = 4,
  parameter int         FIELD_VERTICAL   = 22,
  parameter int         FIELD_HORIZONTAL = 10
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic                                                 start,
  input  logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] f,
  input  logic [2:0]                                           lines,
  input  logic [3:0]                                           hole_col,
  output logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] f_out,
  output logic [2:0]                                           lines_added,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 topped_out
);

  localparam logic [2:0] EMPTY_CELL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0][2:0] f_d;
  logic [FIELD_HORIZONTAL-1:0][2:0]                     garbage_row;
  logic [2:0] rem_q, rem_d;
  logic [3:0] hole_q, hole_d;
  logic [2:0] added_d;
  logic       topped_d;
  logic [2:0] lines_clamped;
  logic [3:0] hole_eff;
  logic       row0_occupied;

  // Request size clamped to MAX_LINES; an out-of-range hole column folds to 0.
  assign lines_clamped = (lines > 3'(MAX_LINES)) ? 3'(MAX_LINES) : lines;
  assign hole_eff      = (int'(hole_col) >= FIELD_HORIZONTAL) ? '0 : hole_col;

  // Row 0 is occupied unless every cell is the empty code (all ones).
  assign row0_occupied = (f_out[0] != '1);

  always_comb begin
    garbage_row = '0;
    for (int unsigned c = 0; c < FIELD_HORIZONTAL; c++) begin
      garbage_row[c] = (c == 32'(hole_q)) ? EMPTY_CELL : GARBAGE_CELL;
    end
  end

  always_comb begin
    state_d  = state_q;
    f_d      = f_out;
    rem_d    = rem_q;
    hole_d   = hole_q;
    added_d  = lines_added;
    topped_d = topped_out;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          f_d      = f;
          added_d  = '0;
          topped_d = 1'b0;
          rem_d    = lines_clamped;
          hole_d   = hole_eff;
          state_d  = (lines_clamped != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        // Dropping start aborts before the shift on this edge, so an abort
        // coinciding with the last row leaves that row un-inserted.
        if (!start) begin
          state_d = IDLE;
        end else begin
          f_d     = {garbage_row, f_out[FIELD_VERTICAL-1:1]};
          added_d = lines_added + 3'd1;
          rem_d   = rem_q - 3'd1;
          if (row0_occupied) begin
            topped_d = 1'b1;
          end
          if (rem_q == 3'd1) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      f_out       <= '1;
      rem_q       <= '0;
      hole_q      <= '0;
      lines_added <= '0;
      topped_out  <= 1'b0;
    end else begin
      state_q     <= state_d;
      f_out       <= f_d;
      rem_q       <= rem_d;
      hole_q      <= hole_d;
      lines_added <= added_d;
      topped_out  <= topped_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule
